// File: rtl/reg_file_sb.sv
// Integer register file with write-first bypassed read ports, one writeback port,
// a per-register busy scoreboard for RAW/WAW issue stalls, flush, and a difftest view.
module reg_file_sb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wen,
  input  logic [AW-1:0]          i_waddr,
  input  logic [XLEN-1:0]        i_wdata,
  input  logic [NUM_RD*AW-1:0]   i_rs_addr,
  input  logic [NUM_RD-1:0]      i_rs_cen,
  output logic [NUM_RD*XLEN-1:0] o_rs_rdata,
  input  logic                   i_iss_valid,
  input  logic                   i_iss_rd_en,
  input  logic [AW-1:0]          i_iss_rd,
  output logic                   o_stall,
  input  logic                   i_flush,
  output logic [NREG-1:0]        o_busy,
  output logic [NREG*XLEN-1:0]   regs_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_hit;
  logic            src_haz;
  logic            waw_haz;
  logic            accept;

  assign wr_hit = i_wen && (i_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  // Read ports and source hazards; a same-cycle writeback resolves the hazard.
  always_comb begin
    o_rs_rdata = '0;
    src_haz    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (i_rs_cen[k] && (i_rs_addr[k*AW +: AW] != '0)) begin
        if (i_wen && (i_waddr == i_rs_addr[k*AW +: AW])) begin
          o_rs_rdata[k*XLEN +: XLEN] = i_wdata;
        end else begin
          o_rs_rdata[k*XLEN +: XLEN] = regs_q[i_rs_addr[k*AW +: AW]];
          if (busy_q[i_rs_addr[k*AW +: AW]]) begin
            src_haz = 1'b1;
          end
        end
      end
    end
  end

  assign waw_haz = i_iss_rd_en && (i_iss_rd != '0) && busy_q[i_iss_rd] &&
                   !(i_wen && (i_waddr == i_iss_rd));
  assign o_stall = i_iss_valid && (src_haz || waw_haz) && !i_flush;
  assign accept  = i_iss_valid && !o_stall && !i_flush;

  // Clear before set so an issue wins over a same-cycle writeback to its rd.
  always_comb begin
    busy_d = busy_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      if (wr_hit) begin
        busy_d[i_waddr] = 1'b0;
      end
      if (accept && i_iss_rd_en && (i_iss_rd != '0)) begin
        busy_d[i_iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy = busy_q;

  always_comb begin
    regs_o = '0;
    for (int r = 1; r < NREG; r++) begin
      if (i_wen && (i_waddr == AW'(r))) begin
        regs_o[r*XLEN +: XLEN] = i_wdata;
      end else begin
        regs_o[r*XLEN +: XLEN] = regs_q[r];
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the single-issue integer register file: NUM_RD combinational read ports with write-first bypass, one writeback port, a per-register busy scoreboard for RAW/WAW hazard detection at issue, a flush, and a flattened difftest view. Sits between decode/issue and writeback in the pipelined core; issue consults `o_stall` before launching an instruction.

## Interface
- `XLEN`, 64, data width
- `NREG`, 32, number of architectural registers; x0 hard-wired to zero
- `AW`, 5, register address width, equal to log2(NREG)
- `NUM_RD`, 2, number of read ports (1..4)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_wen`  in  1  writeback write enable
- `i_waddr`  in  AW  writeback register index
- `i_wdata`  in  XLEN  writeback data
- `i_rs_addr`  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
- `i_rs_cen`  in  NUM_RD  read enables
- `o_rs_rdata`  out  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- `i_iss_valid`  in  1  issue stage presents an instruction
- `i_iss_rd_en`  in  1  the instruction writes a destination register
- `i_iss_rd`  in  AW  destination register index
- `o_stall`  out  1  issue must hold; instruction not accepted this cycle
- `i_flush`  in  1  discard all outstanding writes (pipeline flush)
- `o_busy`  out  NREG  scoreboard bits, bit r set means a write to xr is pending
- `regs_o`  out  NREG*XLEN  difftest view, register r at bits [r*XLEN +: XLEN]

## Operation
- Storage: `regs[NREG]` and `busy[NREG]`. On `rst_n` low, both clear to 0 immediately (async). Reset values: `o_busy`=0, `o_stall`=0, `regs_o`=0, `o_rs_rdata`=0.
- Write: at posedge, if `i_wen` and `i_waddr`≠0, then `regs[i_waddr]` is set to `i_wdata`. Writes to x0 are dropped.
- Read port k, combinationally, first matching rule:
  - addr = 0: 0
  - `i_rs_cen[k]`=0: 0
  - `i_wen` and `i_waddr`=addr: `i_wdata`, the write-first bypass
  - otherwise: `regs[addr]`
- Source hazard on port k: `i_rs_cen[k]`, addr≠0, `busy[addr]`=1, and not (`i_wen` and `i_waddr`=addr).
- WAW hazard: `i_iss_rd_en`, `i_iss_rd`≠0, `busy[i_iss_rd]`=1, and not (`i_wen` and `i_waddr`=`i_iss_rd`).
- `o_stall` = `i_iss_valid` and (any source hazard or WAW hazard) and not `i_flush`.
- Accept = `i_iss_valid` and not `o_stall` and not `i_flush`.
- Busy update at posedge, in priority order:
  - `i_flush`: all bits go to 0. Any issue that cycle is discarded. A same-cycle writeback still updates `regs`.
  - Otherwise, clear: `i_wen` and `i_waddr`≠0 clear `busy[i_waddr]`. Writeback to a non-busy register is legal and is a no-op on busy.
  - Otherwise, set: Accept, `i_iss_rd_en`, and `i_iss_rd`≠0 set `busy[i_iss_rd]`. When set and clear target the same index, set wins and the bit stays 1.
- `busy[0]` is constant 0.
- Difftest: `regs_o[r]` shows `i_wdata` when `i_wen`, `i_waddr`=r, and r≠0; otherwise it shows `regs[r]`. This gives the post-commit view in the commit cycle.

## Timing
- Read and hazard paths are purely combinational, with 0-cycle latency.
- A write is visible on read ports in the same cycle through the bypass, and from `regs` from the next cycle on.
- A busy set is visible on `o_busy` and `o_stall` the cycle after accept.
- Back-to-back dependent pair, for a producer with 1-cycle writeback:
  - the consumer stalls every cycle until the writeback cycle;
  - it is accepted in the writeback cycle using bypassed data.
- `rst_n` asserted mid-operation clears everything asynchronously. There is no pending state after release.

## Test plan
- Reset, then read all ports at x5 with cen=1 → 0. Check `o_busy`=0 and `regs_o` all 0.
- Write x3 = 0xDEADBEEF_00000001 with port0 reading x3 in the same cycle → port0 = 0xDEADBEEF_00000001 combinationally, and the same value next cycle from storage. Write x0 = 5 → x0 still reads 0.
- Issue rd=x7 (accepted). Next cycle, issue with rs1=x7 → `o_stall`=1 and `o_busy[7]`=1. Then writeback x7 = 0x42 → `o_stall`=0 in that cycle, port0 = 0x42, `busy[7]` cleared.
- WAW: x9 busy, issue rd=x9 → stall. Same-cycle writeback x9 with a new issue rd=x9 → accepted and `busy[9]` remains 1.
- Set x4 and x6 busy, assert `i_flush` together with `i_iss_valid` rd=x8 → next cycle `o_busy`=0. x8 is not set.
- Assert `rst_n` low between clock edges while x2 is busy and holds 0x1234 → `o_busy` and `regs_o` go to 0 before the next edge.
